mips_if_stage: RTL
==================

Name: mips_if_stage

Overview:
Instruction-fetch stage of the MipsPipelineCPU five-stage pipeline. It owns the PC register and drives the instruction-ROM address. It also owns the IF/ID pipeline register that feeds Instruction_id and its PC+4 to the decode stage. It consumes the decode stage's Stall and JumpFlag/target outputs to hold, redirect or flush fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_AW, 8, instruction-ROM word-address width
DELAY_SLOT, 0, 1 = no flush on redirect (MIPS delay slot); 0 = flush the wrong-path instruction

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
Stall  input  1  load-use hazard from decode; freezes PC and IF/ID
JumpFlag  input  3  [0] branch taken, [1] J/JAL, [2] JR; resolved in ID
BranchAddr  input  32  branch target from ID
JumpAddr  input  32  J/JAL target from ID
JrAddr  input  32  register target from ID
IMemData  input  32  instruction word from ROM (combinational read of IMemAddr)
PC  output  32  current fetch PC
IMemAddr  output  IMEM_AW  ROM word address = PC[IMEM_AW+1:2]
Instruction_id  output  32  IF/ID instruction
PC4_id  output  32  IF/ID PC+4
Valid_id  output  1  IF/ID holds a real (non-flushed) instruction

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, Instruction_id=32'h0, PC4_id=32'h0, Valid_id=0. Outputs hold these values while reset is low. The first fetch occurs on the first rising edge after release.
- PC next-value priority, evaluated each rising edge:
  1. Stall=1: PC holds and JumpFlag is ignored (the ID instruction is not yet valid to resolve).
  2. JumpFlag[2]: PC <= JrAddr.
  3. JumpFlag[1]: PC <= JumpAddr.
  4. JumpFlag[0]: PC <= BranchAddr.
  5. Otherwise: PC <= PC+4. 32-bit wrap: 32'hFFFF_FFFC+4 = 0.
- Redirect targets have bits [1:0] forced to 0 before loading.
- More than one JumpFlag bit set resolves by the priority above. No error is flagged.
- IF/ID register:
  - Stall=1: hold all three fields.
  - Redirect (any JumpFlag bit, Stall=0) with DELAY_SLOT=0: Instruction_id <= 0 (sll nop), PC4_id <= 0, Valid_id <= 0.
  - Redirect with DELAY_SLOT=1: normal load; the delay-slot instruction proceeds.
  - Normal: Instruction_id <= IMemData, PC4_id <= PC+4, Valid_id <= 1.
- Latency: an instruction at address A appears on Instruction_id one cycle after PC=A. A taken redirect costs one bubble when DELAY_SLOT=0.
- IMemAddr is purely combinational from PC. Out-of-range PC bits above IMEM_AW+1 are ignored, so the ROM aliases.
- Reset asserted mid-operation: all state returns to reset values immediately, with no dependence on clk. Any pending redirect or stall is discarded.
- Stall and redirect asserted together: Stall wins. Decode must re-present JumpFlag in the cycle after Stall drops, and the stage acts on it then.

Test Plan:
- Reset/sequential: hold reset=0 for 100 ns, then release with ROM[i]=32'h2000_0000+i. Required: PC goes 0,4,8,C. Instruction_id lags PC by one cycle: 32'h2000_0000, 32'h2000_0001, and so on. Valid_id=1 from the first edge. PC4_id equals the fetched PC+4.
- Stall: assert Stall for 2 cycles while PC=8. Required: PC stays 8, Instruction_id stays ROM[1] and Valid_id stays 1 for both cycles. Fetch resumes at ROM[2] → ROM[3].
- Branch flush (DELAY_SLOT=0): JumpFlag=3'b001, BranchAddr=32'h40 while PC=C. Required: next PC=40, and Instruction_id=0 with Valid_id=0 for one cycle. The following cycle Instruction_id=ROM[16].
- Priority and alignment: JumpFlag=3'b111 with JrAddr=32'h103, JumpAddr=32'h200, BranchAddr=32'h300. Required: PC=32'h100.
- Stall vs redirect: Stall=1 and JumpFlag=3'b010 in the same cycle. Required: PC is unchanged and there is no flush. The next cycle with Stall=0 and JumpFlag=3'b010 gives PC=JumpAddr.
- DELAY_SLOT=1 and async reset: a branch at PC=8 loads ROM[2] with Valid_id=1 and no bubble. Pulse reset low mid-cycle. Required: PC=0, Instruction_id=0 and Valid_id=0 before the next clk edge.

Source files
------------

// File: rtl/mips_if_stage.sv
// Instruction-fetch stage: PC register, ROM address generation and the IF/ID
// pipeline register. Stall from decode freezes everything; a resolved
// jump/branch from decode redirects the PC and, unless delay slots are in
// use, squashes the wrong-path instruction into a bubble.
module mips_if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_AW    = 8,
    parameter bit          DELAY_SLOT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Stall,
    input  logic [2:0]         JumpFlag,
    input  logic [31:0]        BranchAddr,
    input  logic [31:0]        JumpAddr,
    input  logic [31:0]        JrAddr,
    input  logic [31:0]        IMemData,
    output logic [31:0]        PC,
    output logic [IMEM_AW-1:0] IMemAddr,
    output logic [31:0]        Instruction_id,
    output logic [31:0]        PC4_id,
    output logic               Valid_id
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        redirect;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    // Next-PC selection: stall holds, then JR > J/JAL > branch > sequential.
    always_comb begin
        pc_plus4        = pc_q + 32'd4;
        redirect        = |JumpFlag;
        redirect_target = pc_plus4;
        if (JumpFlag[2]) begin
            redirect_target = JrAddr & 32'hFFFF_FFFC;
        end else if (JumpFlag[1]) begin
            redirect_target = JumpAddr & 32'hFFFF_FFFC;
        end else if (JumpFlag[0]) begin
            redirect_target = BranchAddr & 32'hFFFF_FFFC;
        end

        if (Stall) begin
            pc_d = pc_q;
        end else if (redirect) begin
            pc_d = redirect_target;
        end else begin
            pc_d = pc_plus4;
        end
    end

    // IF/ID next value: hold on stall, bubble on redirect without delay slot.
    always_comb begin
        instr_d = IMemData;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
        if (Stall) begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end else if (redirect && (DELAY_SLOT == 1'b0)) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end
    end

    // PC and IF/ID registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    // ROM is word addressed; upper PC bits alias.
    assign IMemAddr       = pc_q[IMEM_AW+1:2];
    assign PC             = pc_q;
    assign Instruction_id = instr_q;
    assign PC4_id         = pc4_q;
    assign Valid_id       = valid_q;

endmodule
